// File: rtl/fle_cfg_pkg.sv
// fle_cfg_pkg: shared types, constants and the serial CRC-8 step for the FLE config loader
package fle_cfg_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SHIFT, ST_CHECK, ST_SETUP, ST_PULSE, ST_HOLD, ST_DONE} fle_cfg_state_t;
  localparam logic [7:0] FLE_CFG_CRC_POLY = 8'h07;
  localparam int FLE_CFG_CRC_W = 8;
  localparam int FLE_CFG_NUM_CFG_BITS = 70;
  localparam int FLE_CFG_SETTLE_CYCLES = 2;
  localparam int FLE_CFG_WL_PULSE_CYCLES = 4;
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? FLE_CFG_CRC_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/fle_cfg_crc8.sv
// fle_cfg_crc8: bit-serial CRC-8 (poly 0x07, init 0x00) over accepted data bits
// Ports: prog_clk/prog_reset (async, active-high); clear restarts the CRC (and may
// coincide with bit_valid, which then folds bit_in into a fresh CRC); crc is the running value.
module fle_cfg_crc8
  import fle_cfg_pkg::*;
(
  input  logic                     prog_clk,
  input  logic                     prog_reset,
  input  logic                     clear,
  input  logic                     bit_valid,
  input  logic                     bit_in,
  output logic [FLE_CFG_CRC_W-1:0] crc
);
  logic [FLE_CFG_CRC_W-1:0] r_crc;
  logic [FLE_CFG_CRC_W-1:0] w_base;
  assign w_base = clear ? '0 : r_crc;
  always_ff @(posedge prog_clk or posedge prog_reset)
    if (prog_reset) r_crc <= '0;
    else r_crc <= bit_valid ? crc8_step(w_base, bit_in) : w_base;
  assign crc = r_crc;
endmodule

// File: rtl/fle_cfg_bank_loader.sv
// fle_cfg_bank_loader: serial config loader driving one FLE bank's bl/wl through setup/pulse/hold
// Ports: prog_clk, prog_reset (async, active-high); cfg_valid/cfg_data/cfg_ready bit-serial input;
// bl/wl bank programming lines; cfg_busy, cfg_done (sticky), cfg_error (sticky, CRC builds only).
// Build option: define FLE_CFG_CRC_EN to expect 8 trailing CRC-8 bits per frame and add a CHECK cycle.
module fle_cfg_bank_loader
  import fle_cfg_pkg::*;
#(
  parameter int NUM_CFG_BITS    = FLE_CFG_NUM_CFG_BITS,
  parameter int SETTLE_CYCLES   = FLE_CFG_SETTLE_CYCLES,
  parameter int WL_PULSE_CYCLES = FLE_CFG_WL_PULSE_CYCLES
)(
  input  logic                    prog_clk,
  input  logic                    prog_reset,
  input  logic                    cfg_valid,
  input  logic                    cfg_data,
  output logic                    cfg_ready,
  output logic [0:NUM_CFG_BITS-1] bl,
  output logic [0:NUM_CFG_BITS-1] wl,
  output logic                    cfg_busy,
  output logic                    cfg_done,
  output logic                    cfg_error
);
  localparam int CW = $clog2(NUM_CFG_BITS + FLE_CFG_CRC_W);
`ifdef FLE_CFG_CRC_EN
  localparam int FRAME_LEN = NUM_CFG_BITS + FLE_CFG_CRC_W;
`else
  localparam int FRAME_LEN = NUM_CFG_BITS;
`endif
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] DLEN = CW'(NUM_CFG_BITS);
  localparam logic [15:0] S_END = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] P_END = 16'(WL_PULSE_CYCLES - 1);
  fle_cfg_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt;
  logic [15:0] r_tmr;
  logic [0:NUM_CFG_BITS-1] r_shadow;
  logic [0:NUM_CFG_BITS-1] w_shadow;
  logic [0:NUM_CFG_BITS-1] r_bl;
  logic [0:NUM_CFG_BITS-1] r_wl;
  logic r_busy;
  logic r_done;
  logic r_err;
  logic w_idle;
  logic w_acc;
  logic w_data;
  logic w_last;
  assign w_idle = (r_state == ST_IDLE) || (r_state == ST_DONE);
  // ready is gated by reset so it reads 0 throughout reset and 1 right after release
  assign cfg_ready = ~prog_reset & (w_idle | (r_state == ST_SHIFT));
  assign w_acc = cfg_valid & cfg_ready;
  assign w_cnt = w_idle ? '0 : r_cnt;
  assign w_data = w_cnt < DLEN;
  assign w_last = w_cnt == LAST;
  always_comb begin
    w_shadow = r_shadow;
    if (w_acc && w_data) w_shadow[w_cnt] = cfg_data;
  end
`ifdef FLE_CFG_CRC_EN
  logic [FLE_CFG_CRC_W-1:0] w_crc;
  logic [FLE_CFG_CRC_W-1:0] r_rx;
  fle_cfg_crc8 u_crc (
    .prog_clk  (prog_clk),
    .prog_reset(prog_reset),
    .clear     (w_acc & w_idle),
    .bit_valid (w_acc & w_data),
    .bit_in    (cfg_data),
    .crc       (w_crc)
  );
  // received CRC arrives MSB first
  always_ff @(posedge prog_clk or posedge prog_reset)
    if (prog_reset) r_rx <= '0;
    else if (w_acc && !w_data) r_rx <= {r_rx[FLE_CFG_CRC_W-2:0], cfg_data};
`endif
  always_ff @(posedge prog_clk or posedge prog_reset)
    if (prog_reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_tmr    <= '0;
      r_shadow <= '0;
      r_bl     <= '0;
      r_wl     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_shadow <= w_shadow;
      if (w_acc) begin
        r_cnt  <= w_cnt + 1'b1;
        r_busy <= 1'b1;
        if (w_idle) begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
        end
        if (!w_last) r_state <= ST_SHIFT;
        else begin
`ifdef FLE_CFG_CRC_EN
          r_state <= ST_CHECK;
`else
          r_state <= ST_SETUP;
          r_bl    <= w_shadow;
          r_tmr   <= '0;
`endif
        end
      end else
        case (r_state)
`ifdef FLE_CFG_CRC_EN
          ST_CHECK:
            if (r_rx == w_crc) begin
              r_state <= ST_SETUP;
              r_bl    <= r_shadow;
              r_tmr   <= '0;
            end else begin
              r_state <= ST_IDLE;
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
            end
`endif
          ST_SETUP:
            if (r_tmr == S_END) begin
              r_state <= ST_PULSE;
              r_wl    <= '1;
              r_tmr   <= '0;
            end else r_tmr <= r_tmr + 16'd1;
          ST_PULSE:
            if (r_tmr == P_END) begin
              r_state <= ST_HOLD;
              r_wl    <= '0;
              r_tmr   <= '0;
            end else r_tmr <= r_tmr + 16'd1;
          ST_HOLD:
            if (r_tmr == S_END) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else r_tmr <= r_tmr + 16'd1;
          default: ;
        endcase
    end
  assign bl        = r_bl;
  assign wl        = r_wl;
  assign cfg_busy  = r_busy;
  assign cfg_done  = r_done;
  assign cfg_error = r_err;
endmodule

// File: tb/tb_fle_cfg_bank_loader.sv
// tb_fle_cfg_bank_loader: directed + randomized frames checked against a cycle-count reference model
module tb_fle_cfg_bank_loader;
  localparam int N = 70;
  localparam int S = 2;
  localparam int P = 4;
`ifdef FLE_CFG_CRC_EN
  localparam int OFF = 1;
`else
  localparam int OFF = 0;
`endif
  logic prog_clk = 1'b0;
  logic prog_reset = 1'b1;
  logic cfg_valid = 1'b0;
  logic cfg_data = 1'b0;
  logic cfg_ready, cfg_busy, cfg_done, cfg_error;
  logic [0:N-1] bl, wl;
  logic [0:N-1] exp_bl = '0;
  logic [0:N-1] d;
  int checks = 0;
  int errors = 0;

  fle_cfg_bank_loader #(.NUM_CFG_BITS(N), .SETTLE_CYCLES(S), .WL_PULSE_CYCLES(P)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .bl(bl), .wl(wl), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_error(cfg_error)
  );

  always #5 prog_clk = ~prog_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge prog_clk);
    #1;
  endtask

  // CRC as the remainder of long division by x^8+x^2+x+1 over the data followed by 8 zeros
  function automatic logic [7:0] crc_ref(input logic [0:N-1] v);
    logic a[N+8];
    logic [0:8] g;
    logic [7:0] r;
    g = 9'b1_0000_0111;
    for (int i = 0; i < N + 8; i++) a[i] = (i < N) ? v[i] : 1'b0;
    for (int i = 0; i < N; i++)
      if (a[i]) for (int j = 0; j < 9; j++) a[i+j] = a[i+j] ^ g[j];
    for (int j = 0; j < 8; j++) r[7-j] = a[N+j];
    return r;
  endfunction

  // gap: 0 continuous, 1 valid low every third cycle, 2 random gaps
  task automatic send(input logic [0:N-1] v, input int gap, input bit bad);
    logic q[$];
    logic [7:0] c;
    int cyc;
    cyc = 0;
    c = crc_ref(v) ^ {7'd0, bad};
    for (int i = 0; i < N; i++) q.push_back(v[i]);
    if (OFF == 1) for (int i = 7; i >= 0; i--) q.push_back(c[i]);
    foreach (q[j]) begin
      while ((gap == 1 && cyc % 3 == 2) || (gap == 2 && $urandom_range(0, 2) == 0)) begin
        cfg_valid = 1'b0;
        cyc++;
        tick;
      end
      chk("ready_in_frame", cfg_ready, 1'b1);
      cfg_valid = 1'b1;
      cfg_data = q[j];
      cyc++;
      tick;
      chk("busy_in_frame", cfg_busy, 1'b1);
      chk("done_cleared", cfg_done, 1'b0);
      chk("error_cleared", cfg_error, 1'b0);
    end
  endtask

  // cycle c=1 is the first cycle after the edge that took the final frame bit
  task automatic post_commit(input logic [0:N-1] v, input bit hold_valid);
    int last;
    last = 2 * S + P + OFF + 1;
    for (int c = 1; c <= last; c++) begin
      chk("bl_commit", bl, (c >= 1 + OFF) ? v : exp_bl);
      chk("wl_pulse", wl, (c >= S + 1 + OFF && c <= S + P + OFF) ? {N{1'b1}} : {N{1'b0}});
      chk("busy_seq", cfg_busy, c < last);
      chk("done_seq", cfg_done, c == last);
      chk("ready_seq", cfg_ready, c == last);
      chk("error_seq", cfg_error, 1'b0);
      cfg_valid = (c == last) ? 1'b0 : hold_valid;
      if (c < last) tick;
    end
    exp_bl = v;
  endtask

  initial begin
    repeat (2) tick;
    chk("rst_bl", bl, '0);
    chk("rst_wl", wl, '0);
    chk("rst_busy", cfg_busy, 1'b0);
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_error", cfg_error, 1'b0);
    chk("rst_ready", cfg_ready, 1'b0);
    prog_reset = 1'b0;
    #1;
    chk("ready_after_release", cfg_ready, 1'b1);
    tick;
    for (int k = 0; k < N; k++) d[k] = k[0];
    send(d, 0, 1'b0);
    post_commit(d, 1'b1);
    send(d, 1, 1'b0);
    post_commit(d, 1'b0);
    for (int k = 0; k < N; k++) d[k] = $urandom_range(0, 1);
    send(d, 0, 1'b0);
    cfg_valid = 1'b0;
    repeat (S + 1 + OFF) tick;
    chk("pulse_before_reset", wl, {N{1'b1}});
    #1 prog_reset = 1'b1;
    #1;
    chk("reset_wl_async", wl, '0);
    chk("reset_bl_async", bl, '0);
    chk("reset_busy", cfg_busy, 1'b0);
    chk("reset_done", cfg_done, 1'b0);
    chk("reset_ready", cfg_ready, 1'b0);
    tick;
    prog_reset = 1'b0;
    #1;
    chk("ready_after_abort", cfg_ready, 1'b1);
    chk("done_after_abort", cfg_done, 1'b0);
    exp_bl = '0;
    tick;
    send({N{1'b1}}, 0, 1'b0);
    post_commit({N{1'b1}}, 1'b0);
    send('0, 0, 1'b0);
    post_commit('0, 1'b0);
    repeat (3) begin
      for (int k = 0; k < N; k++) d[k] = $urandom_range(0, 1);
      send(d, 2, 1'b0);
      post_commit(d, $urandom_range(0, 1) == 1);
      repeat ($urandom_range(0, 3)) tick;
    end
`ifdef FLE_CFG_CRC_EN
    send({N{1'b1}}, 0, 1'b1);
    cfg_valid = 1'b0;
    chk("check_busy", cfg_busy, 1'b1);
    chk("check_wl", wl, '0);
    chk("check_bl", bl, exp_bl);
    tick;
    chk("crc_error", cfg_error, 1'b1);
    chk("crc_err_busy", cfg_busy, 1'b0);
    chk("crc_err_done", cfg_done, 1'b0);
    chk("crc_err_ready", cfg_ready, 1'b1);
    repeat (S + P + 2) begin
      chk("crc_err_wl", wl, '0);
      chk("crc_err_bl", bl, exp_bl);
      chk("crc_err_sticky", cfg_error, 1'b1);
      tick;
    end
    for (int k = 0; k < N; k++) d[k] = $urandom_range(0, 1);
    send(d, 0, 1'b0);
    post_commit(d, 1'b0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
